// File: rtl/team_06_echo_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// team_06_echo_buffer_ctrl
// Sequencer/arbiter for the echo delay-line SRAM. Once per audio sample it
// optionally reads the sample written `offset` samples ago and hands it back
// to the echo effect, then writes the new sample into a circular buffer.
// Idle slots are granted to a host/debug port.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   sample_strobe      one-cycle pulse per audio sample; search/offset/
//                      save_audio are sampled with it
//   past_output/valid  delayed sample and its one-cycle update pulse
//   busy               high whenever the sequencer is not idle
//   overrun/_clr       sticky dropped-strobe flag and its clear
//   host_*             request/ack host access (req held until ack)
//   mem_*              single-port SRAM interface (read latency MEM_LAT)
//   wr_ptr             current write pointer (debug)
// ---------------------------------------------------------------------------
module team_06_echo_buffer_ctrl #(
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_strobe,
  input  logic              search,
  input  logic [ADDR_W-1:0] offset,
  input  logic [DATA_W-1:0] save_audio,
  output logic [DATA_W-1:0] past_output,
  output logic              past_valid,
  output logic              busy,
  output logic              overrun,
  input  logic              overrun_clr,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] wr_ptr
);

  localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    IDLE, ECHO_RD, ECHO_WAIT, ECHO_WR, HOST_ACC, HOST_WAIT
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] fill_q;
  logic              pend_q;
  logic              pend_search_q;
  logic [ADDR_W-1:0] pend_offset_q;
  logic [DATA_W-1:0] pend_audio_q;
  logic [DATA_W-1:0] audio_q;
  logic [1:0]        lat_q;
  logic              host_we_q;
  logic [DATA_W-1:0] past_output_q;
  logic              past_valid_q;
  logic              overrun_q;
  logic              host_ack_q;
  logic [DATA_W-1:0] host_rdata_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  // Sample selected for service this cycle: the pending one has priority
  // over a fresh strobe (a fresh strobe alongside a pending one is dropped).
  logic              is_idle;
  logic              svc;
  logic              svc_search;
  logic [ADDR_W-1:0] svc_offset;
  logic [DATA_W-1:0] svc_audio;
  logic              svc_read;
  logic              drop;

  always_comb begin
    is_idle    = (state_q == IDLE);
    svc        = is_idle && (pend_q || sample_strobe);
    svc_search = pend_q ? pend_search_q : search;
    svc_offset = pend_q ? pend_offset_q : offset;
    svc_audio  = pend_q ? pend_audio_q  : save_audio;
    // Only read history that has actually been written since reset.
    svc_read   = svc_search && (svc_offset != '0) && (fill_q >= svc_offset);
    drop       = sample_strobe && pend_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      fill_q        <= '0;
      pend_q        <= 1'b0;
      pend_search_q <= 1'b0;
      pend_offset_q <= '0;
      pend_audio_q  <= '0;
      audio_q       <= '0;
      lat_q         <= '0;
      host_we_q     <= 1'b0;
      past_output_q <= '0;
      past_valid_q  <= 1'b0;
      overrun_q     <= 1'b0;
      host_ack_q    <= 1'b0;
      host_rdata_q  <= '0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      past_valid_q <= 1'b0;
      host_ack_q   <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;

      // Drop takes precedence over a simultaneous clear.
      if (drop)             overrun_q <= 1'b1;
      else if (overrun_clr) overrun_q <= 1'b0;

      if (is_idle && pend_q) begin
        pend_q <= 1'b0;
      end else if (sample_strobe && !is_idle && !pend_q) begin
        pend_q        <= 1'b1;
        pend_search_q <= search;
        pend_offset_q <= offset;
        pend_audio_q  <= save_audio;
      end

      case (state_q)
        IDLE: begin
          if (svc) begin
            audio_q <= svc_audio;
            if (svc_read) begin
              state_q    <= ECHO_RD;
              mem_en_q   <= 1'b1;
              mem_addr_q <= wr_ptr_q - svc_offset;
            end else begin
              state_q       <= ECHO_WR;
              past_output_q <= '0;
              past_valid_q  <= 1'b1;
              mem_en_q      <= 1'b1;
              mem_we_q      <= 1'b1;
              mem_addr_q    <= wr_ptr_q;
              mem_wdata_q   <= svc_audio;
            end
          end else if (host_req && !host_ack_q) begin
            // host_ack_q guard: the read ack is shown in IDLE while the
            // requester may still hold host_req for that one cycle.
            state_q     <= HOST_ACC;
            host_we_q   <= host_we;
            host_ack_q  <= host_we;
            mem_en_q    <= 1'b1;
            mem_we_q    <= host_we;
            mem_addr_q  <= host_addr;
            mem_wdata_q <= host_we ? host_wdata : '0;
          end
        end
        ECHO_RD: begin
          state_q <= ECHO_WAIT;
          lat_q   <= LAT_LAST;
        end
        ECHO_WAIT: begin
          if (lat_q == '0) begin
            state_q       <= ECHO_WR;
            past_output_q <= mem_rdata;
            past_valid_q  <= 1'b1;
            mem_en_q      <= 1'b1;
            mem_we_q      <= 1'b1;
            mem_addr_q    <= wr_ptr_q;
            mem_wdata_q   <= audio_q;
          end else begin
            lat_q <= lat_q - 2'd1;
          end
        end
        ECHO_WR: begin
          state_q  <= IDLE;
          wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
          if (fill_q != '1) fill_q <= fill_q + ADDR_W'(1);
        end
        HOST_ACC: begin
          if (host_we_q) begin
            state_q <= IDLE;
          end else begin
            state_q <= HOST_WAIT;
            lat_q   <= LAT_LAST;
          end
        end
        HOST_WAIT: begin
          if (lat_q == '0) begin
            state_q      <= IDLE;
            host_rdata_q <= mem_rdata;
            host_ack_q   <= 1'b1;
          end else begin
            lat_q <= lat_q - 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign past_output = past_output_q;
  assign past_valid  = past_valid_q;
  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;
  assign host_ack    = host_ack_q;
  assign host_rdata  = host_rdata_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign wr_ptr      = wr_ptr_q;

endmodule

// File: doc/team_06_echo_buffer_ctrl.md
Name: team_06_echo_buffer_ctrl

Overview:
Sequencer and arbiter for the echo delay-line memory. Once per audio sample it:
- reads the past sample at (write pointer − offset) and returns it as past_output to the echo effect;
- writes the current save_audio into a circular buffer.
It also grants a single-port SRAM to a host/debug requester in idle slots. It sits between team_06_echo_effect and the delay SRAM macro.

Parameters:
ADDR_W, 13, buffer address width; depth = 2^ADDR_W samples, matches the 13-bit offset
DATA_W, 8, sample width
MEM_LAT, 1, SRAM read latency in cycles (1..3)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (asserted when 0)
sample_strobe  in  1  one-cycle pulse per new audio sample
search  in  1  echo enabled for this sample; sampled with sample_strobe
offset  in  ADDR_W  echo delay in samples; sampled with sample_strobe
save_audio  in  DATA_W  sample to store; sampled with sample_strobe
past_output  out  DATA_W  delayed sample returned to echo effect
past_valid  out  1  one-cycle pulse: past_output updated
busy  out  1  high whenever state != IDLE
overrun  out  1  sticky: a strobe was dropped
overrun_clr  in  1  clears overrun
host_req  in  1  host access request; held until host_ack
host_we  in  1  host write (1) / read (0)
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_ack  out  1  one-cycle completion pulse
host_rdata  out  DATA_W  host read data, valid with host_ack
mem_en  out  1  SRAM access enable
mem_we  out  1  SRAM write enable
mem_addr  out  ADDR_W  SRAM address
mem_wdata  out  DATA_W  SRAM write data
mem_rdata  in  DATA_W  SRAM read data, valid MEM_LAT cycles after read issue
wr_ptr  out  ADDR_W  current write pointer, for debug

Behaviour:
- Reset (rst=0, async):
  - state IDLE; wr_ptr, fill count, past_output, host_rdata = 0.
  - past_valid, host_ack, busy, overrun, mem_en, mem_we = 0.
  - Mid-operation reset aborts immediately; mem_en drops without waiting for a clock.
- States: IDLE, ECHO_RD, ECHO_WAIT, ECHO_WR, HOST_ACC, HOST_WAIT.
- Strobe capture:
  - On a strobe (direct, or from the pending latch), latch search, offset and save_audio into shadow registers.
  - Strobe in a non-IDLE state: set the pending latch (one deep).
  - Strobe while pending is already set: drop it and set overrun.
  - overrun_clr clears overrun. If a drop occurs in the same cycle as overrun_clr, the drop wins (overrun stays 1).
- IDLE priority: pending/new strobe > host_req. If both arrive in the same cycle, echo wins; the host waits.
- Read path taken when search=1 AND offset!=0 AND fill >= offset:
  - ECHO_RD (1 cycle): mem_en=1, mem_we=0, mem_addr = (wr_ptr − offset) mod 2^ADDR_W.
  - ECHO_WAIT: MEM_LAT cycles; capture mem_rdata into past_output on the final WAIT edge.
  - ECHO_WR follows.
- Skip path (any read condition false):
  - past_output := 0.
  - Go directly IDLE→ECHO_WR.
- ECHO_WR (1 cycle):
  - mem_en=1, mem_we=1, mem_addr=wr_ptr, mem_wdata = latched save_audio.
  - past_valid=1.
  - On exit: wr_ptr increments, wrapping 2^ADDR_W−1→0; fill increments, saturating at 2^ADDR_W−1.
  - Next state IDLE.
- Latency, strobe high in cycle 0:
  - Read path: ECHO_RD in cycle 1, past_valid in cycle 2+MEM_LAT.
  - Skip path: past_valid in cycle 1.
- Host access:
  - Write: HOST_ACC drives mem_en=1, mem_we=1; host_ack in the same cycle; then IDLE.
  - Read: HOST_ACC issues the read, HOST_WAIT lasts MEM_LAT cycles, then host_rdata is latched and host_ack pulses; then IDLE.
  - A host access is non-preemptible. A strobe arriving during it goes pending and is served in the next IDLE cycle.
- mem_* outputs are 0 in IDLE. Accesses never overlap.
- fill tracks valid history. Reading older than fill returns 0, not stale or reset SRAM contents.

Test Plan:
- Reset, then 5 strobes with search=1, offset=3, save_audio=10,20,30,40,50 → past_output 0,0,0,10,20; wr_ptr=5; past_valid on read strobes in cycle 2+MEM_LAT.
- Wrap: preload 8191 strobes, then strobe save_audio=0xAA (wr_ptr 8191), next strobe with offset=1 → mem_addr=8191 read; past_output=0xAA; wr_ptr wraps to 0.
- offset=0 or search=0 → no SRAM read; past_output=0; past_valid in cycle 1; write still occurs.
- host_req read of addr 2 in the same cycle as strobe → echo sequence first, then host_ack with host_rdata equal to the stored sample; no overlapping mem_en.
- Strobes on 3 consecutive cycles → first served, second pending and served, third dropped; overrun=1 until overrun_clr.
- rst low during ECHO_WAIT → outputs 0 immediately, wr_ptr=0; next strobe after release takes the skip path (fill=0).
